// File: rtl/serial_word_receiver.sv
// Serial frame receiver (start, WIDTH data bits, optional parity, stop) with a one-word parallel output buffer.
// Latency: a good word appears on pout_o/valid_o one clock after the cycle holding the stop-bit strobe.
// Backpressure: valid_o holds until valid_o&&ready_i; a good word arriving while the buffer is full is dropped and flagged on overrun_o.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   bit_en_i, sin_i       bit strobe and serial data (line idles high)
//   pout_o, valid_o       received word and its valid flag
//   ready_i               consumer accepts the word when valid_o&&ready_i
//   busy_o                a frame is in progress
//   frame_err_o, parity_err_o, overrun_o   one-cycle error pulses
module serial_word_receiver #(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] pout_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             frame_err_o,
    output logic             parity_err_o,
    output logic             overrun_o
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic           ODD  = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_bad_q, par_bad_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;

    // Shift-in candidates; the extra bit lets WIDTH=1 work without special cases.
    logic [WIDTH:0]   ext_msb;
    logic [WIDTH:0]   ext_lsb;
    logic [WIDTH-1:0] shift_next;

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            pout_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            pout_q    <= pout_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
        end
    end

    // Next-state logic: the FSM only moves on a bit strobe.
    always_comb begin
        state_d = state_q;
        if (bit_en_i) begin
            case (state_q)
                S_IDLE:   if (!sin_i) state_d = S_DATA;
                S_DATA:   if (cnt_q == LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output logic.
    always_comb begin
        ext_msb    = {shift_q, sin_i};
        ext_lsb    = {sin_i, shift_q};
        // MSB-first shifts left so the first bit ends at the top;
        // LSB-first shifts right so the first bit ends at bit 0.
        shift_next = (MSB_FIRST != 0) ? ext_msb[WIDTH-1:0] : ext_lsb[WIDTH:1];

        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        pout_d    = pout_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        ovr_d     = 1'b0;

        // Consumer handshake; a word landing this cycle below overrides it.
        if (valid_q && ready_i) valid_d = 1'b0;

        if (bit_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!sin_i) begin
                        cnt_d     = '0;
                        par_bad_d = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q + CW'(1);
                end
                S_PARITY: begin
                    // XOR of data and parity is 0 for good even parity, 1 for good odd parity.
                    par_bad_d = (^shift_q) ^ sin_i ^ ODD;
                end
                S_STOP: begin
                    if (!sin_i) begin
                        ferr_d = 1'b1;
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
                    end else if (!valid_q || ready_i) begin
                        pout_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pout_o       = pout_q;
    assign valid_o      = valid_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = ovr_q;

endmodule
